spi_master_multi: RTL
=====================

# spi_master_multi

Parametrised SPI master that replaces the fixed 8-bit, single-slave, mode-0 master in the transceiver datapath. It adds:
- configurable word width, SCK divider and chip-select count;
- per-transfer CPOL/CPHA;
- CC1101-style CHIP_RDYn wait with timeout;
- held-SS burst transfers.

It sits between the command sequencer (spi_mode_config2 successor) and the board SPI pins, on the 26 MHz PLL clock.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per transfer, MSB first, >= 2
- CLK_DIV, 2, clk cycles per SCK half-period, >= 1
- NUM_SS, 2, number of chip-select lines, >= 1
- SS_GUARD, 2, clk cycles between SS assert and first SCK edge, and between last SCK edge and SS release, >= 1
- RDY_TIMEOUT, 1024, max clk cycles to wait for MISO low after guard; 0 disables the ready wait

Ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request, accepted only when busy=0
- cpol  in  1  SCK idle level, latched at accept
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept
- ss_sel  in  $clog2(NUM_SS) (min 1)  slave index, latched at accept
- hold_ss  in  1  keep SS asserted after this transfer; latched at accept
- data_in  in  DATA_WIDTH  transmit word, latched at accept
- miso  in  1  serial input
- mosi  out  1  serial output
- sck  out  1  serial clock
- ss_n  out  NUM_SS  active-low selects
- busy  out  1  transfer in progress
- chip_rdy  out  1  registered ~miso while any SS is asserted, else 0
- new_data  out  1  one-cycle pulse, data_out valid
- data_out  out  DATA_WIDTH  received word, held until next new_data
- err  out  1  one-cycle pulse on ready timeout

## Operation
Reset values: mosi=0, sck=0, ss_n=all 1, busy=0, chip_rdy=0, new_data=0, data_out=0, err=0, latched cpol=0, state=IDLE. Assertion of rst mid-transfer forces these values immediately; the transfer is lost and no new_data or err pulse is produced.

States:
- IDLE
  - sck = latched cpol.
  - start with ss_sel >= NUM_SS is ignored.
  - On a valid start, latch all inputs and set busy=1 next cycle.
  - If SS is held for the same ss_sel: go to SHIFT (skip guard and ready wait).
  - If SS is held for a different ss_sel: release all SS for 1 cycle, then go to SETUP.
  - Otherwise: go to SETUP.
- SETUP
  - ss_n[sel]=0.
  - Count SS_GUARD cycles.
  - If RDY_TIMEOUT > 0, wait until miso=0.
  - On miso=0 go to SHIFT.
  - If RDY_TIMEOUT cycles elapse after the guard with miso still 1, go to ABORT.
- SHIFT
  - Runs DATA_WIDTH SCK periods of 2*CLK_DIV cycles each.
  - cpha=0: the MSB is on mosi on SHIFT entry; miso is sampled on each leading edge; mosi shifts on each trailing edge.
  - cpha=1: mosi shifts on each leading edge; miso is sampled on each trailing edge.
  - Leading edge = sck leaving cpol level.
  - After the final trailing edge, sck = cpol; go to HOLD.
- HOLD
  - SS_GUARD cycles.
  - On exit: data_out <= shift register, new_data=1, busy=0.
  - ss_n[sel] is released unless hold_ss was latched.
  - Go to IDLE.
- ABORT
  - 1 cycle: err=1, busy=0, all ss_n=1, data_out unchanged.
  - Go to IDLE.

Rules:
- start while busy=1 is ignored.
- Input changes while busy=1 have no effect.
- hold_ss=0 on a burst continuation releases SS at that transfer's HOLD exit.

## Timing
- Accept cycle = A.
- Fresh transfer, miso already 0: new_data at A + 1 + SS_GUARD + 2*CLK_DIV*DATA_WIDTH + SS_GUARD. With defaults: A+37. Each cycle waiting on miso adds 1.
- Burst continuation: new_data at A + 1 + 2*CLK_DIV*DATA_WIDTH + SS_GUARD.
- busy is high from A+1 to the new_data cycle exclusive.
- The next start is accepted in the new_data cycle at the earliest.
- Timeout: err at A + 1 + SS_GUARD + RDY_TIMEOUT.
- Fresh transfer: ss_n falls at A+1. First SCK edge at A + 1 + SS_GUARD + CLK_DIV.
- chip_rdy lags miso by 1 cycle.

## Test plan
- Defaults, mode 0, ss_sel=0, data_in=8'hA5, slave returns 8'h3C, miso low at SS:
  - mosi bits 1,0,1,0,0,1,0,1;
  - ss_n=2'b10 at A+1;
  - new_data at A+37 with data_out=8'h3C;
  - ss_n=2'b11 after.
- Sweep all four CPOL/CPHA modes with data_in=8'h81 looped back to miso: data_out=8'h81 in each mode; sck idles at cpol before and after.
- miso held high, RDY_TIMEOUT=16: err pulse at A+19, ss_n=all 1, busy=0, data_out unchanged, no new_data.
- Burst: hold_ss=1 with 8'h11, then same ss_sel with 8'h22 and hold_ss=0:
  - ss_n[0] stays low through both transfers;
  - second new_data at A+35;
  - SS released after.
  - Repeat with a different ss_sel second: one cycle all-high between selects.
- rst pulsed mid-SHIFT: all outputs at reset values within the reset cycle; a subsequent start completes normally. start with ss_sel=2 (NUM_SS=2) and start while busy are both ignored.

Source files
------------

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: per-transfer CPOL/CPHA, multi-slave select,
// CHIP_RDYn wait with timeout, and held-SS burst transfers.
module spi_master_multi #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_DIV     = 2,
  parameter int NUM_SS      = 2,
  parameter int SS_GUARD    = 2,
  parameter int RDY_TIMEOUT = 1024,
  localparam int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [SS_W-1:0]       ss_sel,
  input  logic                  hold_ss,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sck,
  output logic [NUM_SS-1:0]     ss_n,
  output logic                  busy,
  output logic                  chip_rdy,
  output logic                  new_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err
);

  localparam int CNT_MAX = SS_GUARD + RDY_TIMEOUT + CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int EW      = $clog2(2 * DATA_WIDTH);

  localparam logic [CW-1:0]   GUARD_LAST = CW'(SS_GUARD - 1);
  localparam logic [CW-1:0]   WAIT_LAST  = CW'(SS_GUARD - 1 + RDY_TIMEOUT);
  localparam logic [CW-1:0]   DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO   = CW'(0);
  localparam logic [EW-1:0]   EDGE_LAST  = EW'(2 * DATA_WIDTH - 1);
  localparam logic [EW-1:0]   EDGE_ONE   = EW'(1);
  localparam logic [EW-1:0]   EDGE_ZERO  = EW'(0);
  localparam logic [SS_W:0]   SEL_LIMIT  = (SS_W + 1)'(NUM_SS);
  localparam logic [NUM_SS-1:0] SS_NONE  = {NUM_SS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_SETUP   = 3'd2,
    S_SHIFT   = 3'd3,
    S_HOLD    = 3'd4,
    S_ABORT   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [SS_W-1:0]       sel_q, sel_d;
  logic                  hold_q, hold_d;
  logic                  held_q, held_d;
  logic                  mosi_q, mosi_d;
  logic                  sck_q, sck_d;
  logic [NUM_SS-1:0]     ss_n_q, ss_n_d;
  logic                  busy_q, busy_d;
  logic                  chip_rdy_q, chip_rdy_d;
  logic                  new_data_q, new_data_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  err_q, err_d;
  logic                  sel_ok;

  function automatic logic [NUM_SS-1:0] sel_mask(input logic [SS_W-1:0] sel);
    sel_mask = NUM_SS'(1'b1) << sel;
  endfunction

  assign sel_ok = ({1'b0, ss_sel} < SEL_LIMIT);

  // Next-state, datapath and output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sel_d      = sel_q;
    hold_d     = hold_q;
    held_d     = held_q;
    mosi_d     = mosi_q;
    sck_d      = sck_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    new_data_d = 1'b0;
    err_d      = 1'b0;
    data_out_d = data_out_q;
    chip_rdy_d = ~(&ss_n_q) & ~miso;

    case (state_q)
      S_IDLE: begin
        sck_d = cpol_q;
        if (start && sel_ok) begin
          cpol_d = cpol;
          cpha_d = cpha;
          sel_d  = ss_sel;
          hold_d = hold_ss;
          tx_d   = data_in;
          cnt_d  = CNT_ZERO;
          edge_d = EDGE_ZERO;
          sck_d  = cpol;
          busy_d = 1'b1;
          if (held_q && (ss_sel == sel_q)) begin
            state_d = S_SHIFT;
            if (!cpha) begin
              mosi_d = data_in[DATA_WIDTH-1];
              tx_d   = {data_in[DATA_WIDTH-2:0], 1'b0};
            end else begin
              mosi_d = 1'b0;
            end
          end else if (held_q) begin
            state_d = S_RELEASE;
            ss_n_d  = SS_NONE;
            held_d  = 1'b0;
          end else begin
            state_d = S_SETUP;
            ss_n_d  = ~sel_mask(ss_sel);
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      S_RELEASE: begin
        state_d = S_SETUP;
        ss_n_d  = ~sel_mask(sel_q);
        cnt_d   = CNT_ZERO;
      end

      S_SETUP: begin
        // Ready is polled from the last guard cycle on; the wait window follows the guard.
        if (cnt_q >= GUARD_LAST) begin
          if ((RDY_TIMEOUT == 0) || !miso) begin
            state_d = S_SHIFT;
            cnt_d   = CNT_ZERO;
            edge_d  = EDGE_ZERO;
            if (!cpha_q) begin
              mosi_d = tx_q[DATA_WIDTH-1];
              tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
              mosi_d = 1'b0;
            end
          end else if (cnt_q == WAIT_LAST) begin
            state_d = S_ABORT;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            ss_n_d  = SS_NONE;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = CNT_ZERO;
          sck_d  = ~sck_q;
          edge_d = edge_q + EDGE_ONE;
          // Even edge count = leading edge; sample on leading when cpha=0, trailing when cpha=1.
          if (edge_q[0] == cpha_q) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], miso};
          end else begin
            mosi_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (edge_q == EDGE_LAST) begin
            state_d = S_HOLD;
            sck_d   = cpol_q;
            mosi_d  = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HOLD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d    = S_IDLE;
          cnt_d      = CNT_ZERO;
          data_out_d = rx_q;
          new_data_d = 1'b1;
          busy_d     = 1'b0;
          if (hold_q) begin
            held_d = 1'b1;
          end else begin
            held_d = 1'b0;
            ss_n_d = SS_NONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ss_n_d  = SS_NONE;
        busy_d  = 1'b0;
        held_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      edge_q     <= EDGE_ZERO;
      tx_q       <= {DATA_WIDTH{1'b0}};
      rx_q       <= {DATA_WIDTH{1'b0}};
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sel_q      <= {SS_W{1'b0}};
      hold_q     <= 1'b0;
      held_q     <= 1'b0;
      mosi_q     <= 1'b0;
      sck_q      <= 1'b0;
      ss_n_q     <= SS_NONE;
      busy_q     <= 1'b0;
      chip_rdy_q <= 1'b0;
      new_data_q <= 1'b0;
      data_out_q <= {DATA_WIDTH{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      mosi_q     <= mosi_d;
      sck_q      <= sck_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      chip_rdy_q <= chip_rdy_d;
      new_data_q <= new_data_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign ss_n     = ss_n_q;
  assign busy     = busy_q;
  assign chip_rdy = chip_rdy_q;
  assign new_data = new_data_q;
  assign data_out = data_out_q;
  assign err      = err_q;

endmodule
